// File: rtl/iomem_button_irq.sv
// Memory-mapped button/sense-input peripheral: synchronise, debounce, latch
// edge events into a W1C pending register and raise a level interrupt.
module iomem_button_irq #(
  parameter logic [7:0]  ADDR_HI         = 8'h05,
  parameter int unsigned N_INPUTS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 12000,
  parameter logic [7:0]  INIT_LEVEL      = 8'h00
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                iomem_valid,
  output logic                iomem_ready,
  input  logic [3:0]          iomem_wstrb,
  input  logic [31:0]         iomem_addr,
  input  logic [31:0]         iomem_wdata,
  output logic [31:0]         iomem_rdata,
  input  logic [N_INPUTS-1:0] btn_in,
  output logic                irq
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [N_INPUTS-1:0] INIT = INIT_LEVEL[N_INPUTS-1:0];

  localparam logic [1:0] REG_STATE   = 2'd0;
  localparam logic [1:0] REG_PENDING = 2'd1;
  localparam logic [1:0] REG_RISE_EN = 2'd2;
  localparam logic [1:0] REG_FALL_EN = 2'd3;

  logic [N_INPUTS-1:0]            sync1_q, sync1_d;
  logic [N_INPUTS-1:0]            sync_q, sync_d;
  logic [N_INPUTS-1:0]            stable_q, stable_d;
  logic [N_INPUTS-1:0]            stable_prev_q, stable_prev_d;
  logic [N_INPUTS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N_INPUTS-1:0]            pending_q, pending_d;
  logic [N_INPUTS-1:0]            rise_en_q, rise_en_d;
  logic [N_INPUTS-1:0]            fall_en_q, fall_en_d;
  logic                           ready_q, ready_d;
  logic [31:0]                    rdata_q, rdata_d;
  logic                           irq_q, irq_d;

  logic                           req;
  logic                           wr;
  logic [1:0]                     sel;
  logic [N_INPUTS-1:0]            wbits;
  logic [N_INPUTS-1:0]            rise_ev;
  logic [N_INPUTS-1:0]            fall_ev;
  logic                           unused_bus_bits;

  // Bits of the bus that this block does not decode.
  assign unused_bus_bits = ^{iomem_addr[23:4], iomem_addr[1:0],
                             iomem_wstrb[3:1], iomem_wdata[31:N_INPUTS]};

  // Synchroniser and per-input debounce counters.
  always_comb begin
    sync1_d       = btn_in;
    sync_d        = sync1_q;
    stable_d      = stable_q;
    stable_prev_d = stable_q;
    cnt_d         = cnt_q;
    for (int i = 0; i < int'(N_INPUTS); i++) begin
      if (sync_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Bus decode, register writes, edge capture and read data.
  always_comb begin
    req     = iomem_valid && !ready_q && (iomem_addr[31:24] == ADDR_HI);
    wr      = req && iomem_wstrb[0];
    sel     = iomem_addr[3:2];
    wbits   = iomem_wdata[N_INPUTS-1:0];
    rise_ev = stable_q & ~stable_prev_q & rise_en_q;
    fall_ev = ~stable_q & stable_prev_q & fall_en_q;

    pending_d = pending_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    ready_d   = req;
    rdata_d   = '0;

    if (wr) begin
      case (sel)
        REG_PENDING: pending_d = pending_q & ~wbits;
        REG_RISE_EN: rise_en_d = wbits;
        REG_FALL_EN: fall_en_d = wbits;
        default:     ;
      endcase
    end
    // A new event in the same cycle as its W1C clear keeps the bit set.
    pending_d = pending_d | rise_ev | fall_ev;

    if (req) begin
      case (sel)
        REG_STATE:   rdata_d = 32'(stable_q);
        REG_PENDING: rdata_d = 32'(pending_q);
        REG_RISE_EN: rdata_d = 32'(rise_en_q);
        default:     rdata_d = 32'(fall_en_q);
      endcase
    end

    irq_d = |pending_d;
  end

  // State registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q       <= INIT;
      sync_q        <= INIT;
      stable_q      <= INIT;
      stable_prev_q <= INIT;
      cnt_q         <= '0;
      pending_q     <= '0;
      rise_en_q     <= '0;
      fall_en_q     <= '0;
      ready_q       <= 1'b0;
      rdata_q       <= '0;
      irq_q         <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync_q        <= sync_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      rise_en_q     <= rise_en_d;
      fall_en_q     <= fall_en_d;
      ready_q       <= ready_d;
      rdata_q       <= rdata_d;
      irq_q         <= irq_d;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_iomem_button_irq.sv
// Scoreboard bench for iomem_button_irq: bus accesses push expected read
// data, a negedge monitor pops and compares on every ready pulse.
module tb_iomem_button_irq;

  localparam int unsigned N = 4;
  localparam int unsigned D = 4;
  localparam logic [31:0] BASE = 32'h0500_0000;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         iomem_valid = 1'b0;
  logic         iomem_ready;
  logic [3:0]   iomem_wstrb = 4'h0;
  logic [31:0]  iomem_addr = 32'h0;
  logic [31:0]  iomem_wdata = 32'h0;
  logic [31:0]  iomem_rdata;
  logic [N-1:0] btn_in = '0;
  logic         irq;

  logic [31:0]  exp_q[$];
  logic [31:0]  exp_v;
  logic         ready_prev = 1'b0;
  int           n_checks = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  iomem_button_irq #(
    .ADDR_HI(8'h05),
    .N_INPUTS(N),
    .DEBOUNCE_CYCLES(D),
    .INIT_LEVEL(8'h00)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .iomem_valid(iomem_valid),
    .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata),
    .btn_in(btn_in),
    .irq(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop an expectation on each ready pulse; rdata must be 0 otherwise.
  always @(negedge clk) begin
    if (resetn) begin
      if (iomem_ready) begin
        check("ready_width", 32'(ready_prev), 32'h0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ready: got ready=1 expected no access at %0t", $time);
        end else begin
          exp_v = exp_q.pop_front();
          check("rdata", iomem_rdata, exp_v);
        end
      end else begin
        check("rdata_idle", iomem_rdata, 32'h0);
      end
    end
    ready_prev = iomem_ready;
  end

  // One bus access; called just after a rising edge, returns just after the ready edge.
  task automatic bus(input logic [31:0] addr, input logic [3:0] wstrb,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata);
    bit done = 1'b0;
    exp_q.push_back(exp_rdata);
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wstrb = wstrb;
    iomem_wdata = wdata;
    for (int i = 0; i < 8 && !done; i++) begin
      @(posedge clk);
      #1;
      if (iomem_ready) done = 1'b1;
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL bus_timeout: got no ready expected ready for addr 0x%08h", addr);
      void'(exp_q.pop_back());
    end
  endtask

  task automatic rd(input logic [3:0] off, input logic [31:0] exp_rdata);
    bus(BASE | 32'(off), 4'h0, 32'h0, exp_rdata);
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] data, input logic [31:0] old);
    bus(BASE | 32'(off), 4'h1, data, old);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cycles(3);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_ready", 32'(iomem_ready), 32'h0);
    check("reset_rdata", iomem_rdata, 32'h0);
    resetn = 1'b1;
    cycles(1);
    rd(4'h0, 32'h0);
    rd(4'h4, 32'h0);
    rd(4'h8, 32'h0);
    rd(4'hC, 32'h0);
    check("idle_irq", 32'(irq), 32'h0);

    // Debounce accept with exact latency: pin change lands before edge k
    wr(4'h8, 32'h1, 32'h0);
    btn_in[0] = 1'b1;
    cycles(5);                 // just after edge k+4
    rd(4'h0, 32'h0);           // sampled at edge k+5: stable not yet updated
    check("irq_not_early", 32'(irq), 32'h0);
    cycles(1);                 // just after edge k+6
    check("irq_on_time", 32'(irq), 32'h1);
    rd(4'h0, 32'h1);
    rd(4'h4, 32'h1);

    // W1C drops irq in the completing cycle
    wr(4'h4, 32'h1, 32'h1);
    check("w1c_irq_clear", 32'(irq), 32'h0);

    // Glitch reject: 3-cycle pulse on input 1
    wr(4'h8, 32'hF, 32'h1);
    btn_in[1] = 1'b1;
    cycles(3);
    btn_in[1] = 1'b0;
    for (int i = 0; i < 10; i++) check("glitch_irq", 32'(irq), 32'h0);
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      check("glitch_irq", 32'(irq), 32'h0);
    end
    rd(4'h0, 32'h1);
    rd(4'h4, 32'h0);

    // Build PENDING=0x3: fall on input 0, rise on input 1
    wr(4'hC, 32'hF, 32'h0);
    btn_in[0] = 1'b0;
    btn_in[1] = 1'b1;
    cycles(10);
    rd(4'h0, 32'h2);
    rd(4'h4, 32'h3);
    wr(4'h4, 32'h1, 32'h3);
    check("w1c_partial_irq", 32'(irq), 32'h1);
    rd(4'h4, 32'h2);

    // Collision: fall event on input 1 sets pending at edge k+6, same edge as the W1C
    btn_in[1] = 1'b0;
    cycles(6);                 // just after edge k+5
    wr(4'h4, 32'h2, 32'h2);
    rd(4'h4, 32'h2);
    check("collision_irq", 32'(irq), 32'h1);

    // Address decode
    wr(4'h8, 32'h1, 32'hF);
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0300_0008;
    iomem_wstrb = 4'hF;
    iomem_wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      cycles(1);
      check("unsel_ready", 32'(iomem_ready), 32'h0);
      check("unsel_rdata", iomem_rdata, 32'h0);
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    cycles(1);
    rd(4'h8, 32'h1);
    bus(32'h0500_0008, 4'hF, 32'hFFFF_FFFF, 32'h1);
    rd(4'h8, 32'hF);

    // Async reset two cycles into a debounce on input 2
    btn_in[2] = 1'b1;
    cycles(4);
    check("pre_reset_irq", 32'(irq), 32'h1);
    #3;
    resetn = 1'b0;
    #1;
    check("async_irq", 32'(irq), 32'h0);
    check("async_ready", 32'(iomem_ready), 32'h0);
    check("async_rdata", iomem_rdata, 32'h0);
    cycles(2);
    resetn = 1'b1;
    cycles(12);
    check("post_reset_irq", 32'(irq), 32'h0);
    rd(4'h4, 32'h0);
    rd(4'h0, 32'h4);
    rd(4'h8, 32'h0);
    rd(4'hC, 32'h0);
    check("post_reset_irq2", 32'(irq), 32'h0);

    cycles(3);
    check("scoreboard_drain", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
